// File: rtl/vote_sched_if.sv
// Result handshake between the tree-engine arbiter and the batch controller,
// plus the per-accept strobe and slot index that go on to the vote buffer.
//   i_res_vld   : result valid from the tree-engine arbiter
//   o_res_rdy   : controller can take a result this cycle
//   o_accum_vld : accumulate strobe to the vote buffer (high on accept)
//   o_vote_slot : vote slot the buffer accumulates into
// modport slave  : the controller side
// modport master : the arbiter / vote-buffer side
interface vote_sched_if #(
  parameter int BRAM_AWIDTH = 14
) ();
  logic                   i_res_vld;
  logic                   o_res_rdy;
  logic                   o_accum_vld;
  logic [BRAM_AWIDTH-1:0] o_vote_slot;

  modport slave (
    input  i_res_vld,
    output o_res_rdy,
    output o_accum_vld,
    output o_vote_slot
  );

  modport master (
    output i_res_vld,
    input  o_res_rdy,
    input  o_accum_vld,
    input  o_vote_slot
  );
endinterface

// File: rtl/vote_sched.sv
// Batch controller for the vote accumulation buffer.
// Sequences one inference batch: validates and latches the configuration on
// i_start, accepts per-tree results spaced far enough apart that the vote
// buffer's read-modify-write pipeline never sees a hazard, drains that
// pipeline, then hands the BRAM to the PS until i_ps_ack.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_start         : begin batch pulse (only honoured in IDLE)
//   i_is_clf, i_n_labels, i_n_trees, i_n_samples : batch configuration
//   res             : result handshake / accumulate strobe / vote slot
//   o_is_clf, o_n_labels : latched configuration to the vote buffer
//   o_is_ps_read, o_done_irq : BRAM owned by PS (high in PS_READ)
//   o_busy          : controller not idle
//   o_cfg_err       : one-cycle pulse on a rejected start
//   i_ps_ack        : PS finished reading (only honoured in PS_READ)
module vote_sched #(
  parameter int N_LABELS_WIDTH = 4,
  parameter int BRAM_AWIDTH    = 14,
  parameter int TREE_WIDTH     = 8,
  parameter int HAZARD_GAP     = 5,
  parameter int DRAIN_CYCLES   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_is_clf,
  input  logic [N_LABELS_WIDTH-1:0] i_n_labels,
  input  logic [TREE_WIDTH-1:0]     i_n_trees,
  input  logic [BRAM_AWIDTH-1:0]    i_n_samples,
  vote_sched_if.slave               res,
  output logic                      o_is_clf,
  output logic [N_LABELS_WIDTH-1:0] o_n_labels,
  output logic                      o_is_ps_read,
  output logic                      o_busy,
  output logic                      o_done_irq,
  output logic                      o_cfg_err,
  input  logic                      i_ps_ack
);

  localparam int PW          = N_LABELS_WIDTH + BRAM_AWIDTH;
  localparam int MAX_LABELS  = 2**N_LABELS_WIDTH - 1;
  localparam int MAX_SPACING = (MAX_LABELS > HAZARD_GAP) ? MAX_LABELS : HAZARD_GAP;
  localparam int GAP_W       = $clog2(MAX_SPACING + 1);
  localparam int DRAIN_W     = $clog2(DRAIN_CYCLES + MAX_LABELS + 1);
  localparam logic [PW-1:0] CAPACITY = PW'(2**BRAM_AWIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, PS_READ} state_t;

  state_t                    state_reg, state_next;
  logic [BRAM_AWIDTH-1:0]    slot_reg, slot_next;
  logic [TREE_WIDTH-1:0]     tree_reg, tree_next;
  logic [GAP_W-1:0]          gap_reg, gap_next;
  logic [DRAIN_W-1:0]        drain_reg, drain_next;
  logic                      is_clf_reg, is_clf_next;
  logic [N_LABELS_WIDTH-1:0] n_labels_reg, n_labels_next;
  logic [TREE_WIDTH-1:0]     n_trees_m1_reg, n_trees_m1_next;
  logic [BRAM_AWIDTH-1:0]    n_samples_m1_reg, n_samples_m1_next;
  logic [GAP_W-1:0]          spacing_m1_reg, spacing_m1_next;
  logic [DRAIN_W-1:0]        drain_load_reg, drain_load_next;
  logic                      cfg_err_reg, cfg_err_next;

  logic          res_rdy;
  logic          accept;
  logic [PW-1:0] cap_prod;
  logic          cfg_bad;
  logic [GAP_W-1:0] spacing;

  // Capacity check at full product width so an over-size batch cannot alias
  // back into range.
  assign cap_prod = PW'(i_n_labels) * PW'(i_n_samples);
  assign cfg_bad  = (i_n_trees == '0) || (i_n_samples == '0) ||
                    (i_is_clf && ((i_n_labels < N_LABELS_WIDTH'(2)) ||
                                  (cap_prod > CAPACITY)));

  // A classification accept writes n_labels consecutive vote words, so the
  // spacing must cover whichever is longer: the label burst or the hazard gap.
  always_comb begin
    spacing = GAP_W'(HAZARD_GAP);
    if (i_is_clf && (GAP_W'(i_n_labels) > GAP_W'(HAZARD_GAP))) begin
      spacing = GAP_W'(i_n_labels);
    end
  end

  always_comb begin
    state_next        = state_reg;
    slot_next         = slot_reg;
    tree_next         = tree_reg;
    gap_next          = gap_reg;
    drain_next        = drain_reg;
    is_clf_next       = is_clf_reg;
    n_labels_next     = n_labels_reg;
    n_trees_m1_next   = n_trees_m1_reg;
    n_samples_m1_next = n_samples_m1_reg;
    spacing_m1_next   = spacing_m1_reg;
    drain_load_next   = drain_load_reg;
    cfg_err_next      = 1'b0;
    res_rdy           = 1'b0;
    accept            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          if (cfg_bad) begin
            cfg_err_next = 1'b1;
          end else begin
            is_clf_next       = i_is_clf;
            n_labels_next     = i_n_labels;
            n_trees_m1_next   = i_n_trees - TREE_WIDTH'(1);
            n_samples_m1_next = i_n_samples - BRAM_AWIDTH'(1);
            spacing_m1_next   = spacing - GAP_W'(1);
            drain_load_next   = i_is_clf ? DRAIN_W'(DRAIN_CYCLES) + DRAIN_W'(i_n_labels)
                                         : DRAIN_W'(DRAIN_CYCLES);
            slot_next         = '0;
            tree_next         = '0;
            gap_next          = '0;
            state_next        = RUN;
          end
        end
      end

      RUN: begin
        res_rdy = (gap_reg == '0);
        accept  = res.i_res_vld & res_rdy;
        if (gap_reg != '0) begin
          gap_next = gap_reg - GAP_W'(1);
        end
        if (accept) begin
          gap_next = spacing_m1_reg;
          if (tree_reg == n_trees_m1_reg) begin
            tree_next = '0;
            // The final slot is held rather than incremented so a full
            // 2^BRAM_AWIDTH batch never wraps the slot counter.
            if (slot_reg == n_samples_m1_reg) begin
              state_next = DRAIN;
              drain_next = drain_load_reg;
            end else begin
              slot_next = slot_reg + BRAM_AWIDTH'(1);
            end
          end else begin
            tree_next = tree_reg + TREE_WIDTH'(1);
          end
        end
      end

      DRAIN: begin
        // The edge that brings the count to zero is the one that hands over.
        if (drain_reg <= DRAIN_W'(1)) begin
          drain_next = '0;
          state_next = PS_READ;
        end else begin
          drain_next = drain_reg - DRAIN_W'(1);
        end
      end

      PS_READ: begin
        if (i_ps_ack) begin
          state_next = IDLE;
          slot_next  = '0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg         <= '0;
      tree_reg         <= '0;
      gap_reg          <= '0;
      drain_reg        <= '0;
      is_clf_reg       <= 1'b0;
      n_labels_reg     <= '0;
      n_trees_m1_reg   <= '0;
      n_samples_m1_reg <= '0;
      spacing_m1_reg   <= '0;
      drain_load_reg   <= '0;
      cfg_err_reg      <= 1'b0;
    end else begin
      slot_reg         <= slot_next;
      tree_reg         <= tree_next;
      gap_reg          <= gap_next;
      drain_reg        <= drain_next;
      is_clf_reg       <= is_clf_next;
      n_labels_reg     <= n_labels_next;
      n_trees_m1_reg   <= n_trees_m1_next;
      n_samples_m1_reg <= n_samples_m1_next;
      spacing_m1_reg   <= spacing_m1_next;
      drain_load_reg   <= drain_load_next;
      cfg_err_reg      <= cfg_err_next;
    end
  end

  assign res.o_res_rdy   = res_rdy;
  assign res.o_accum_vld = accept;
  assign res.o_vote_slot = slot_reg;
  assign o_is_clf        = is_clf_reg;
  assign o_n_labels      = n_labels_reg;
  // Decoded straight from state so ownership returns to the fabric the
  // moment reset is asserted.
  assign o_is_ps_read    = (state_reg == PS_READ);
  assign o_done_irq      = (state_reg == PS_READ);
  assign o_busy          = (state_reg != IDLE);
  assign o_cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_vote_sched.sv
module tb_vote_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_is_clf = 1'b0;
  logic [3:0]  i_n_labels = '0;
  logic [7:0]  i_n_trees = '0;
  logic [13:0] i_n_samples = '0;
  logic        i_ps_ack = 1'b0;
  logic        o_is_clf;
  logic [3:0]  o_n_labels;
  logic        o_is_ps_read, o_busy, o_done_irq, o_cfg_err;

  vote_sched_if #(.BRAM_AWIDTH(14)) res_if ();

  vote_sched dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_is_clf(i_is_clf),
    .i_n_labels(i_n_labels), .i_n_trees(i_n_trees), .i_n_samples(i_n_samples),
    .res(res_if), .o_is_clf(o_is_clf), .o_n_labels(o_n_labels),
    .o_is_ps_read(o_is_ps_read), .o_busy(o_busy), .o_done_irq(o_done_irq),
    .o_cfg_err(o_cfg_err), .i_ps_ack(i_ps_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  int          acc_cyc[32];
  logic [13:0] acc_slot[32];
  int          n_acc;
  int          ps_cyc;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic do_start(input logic clf, input logic [3:0] nl, input logic [7:0] nt,
                          input logic [13:0] ns);
    i_is_clf = clf; i_n_labels = nl; i_n_trees = nt; i_n_samples = ns; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    // Scramble the configuration inputs: only the latched copy may matter.
    i_is_clf = ~clf; i_n_labels = 4'd15; i_n_trees = 8'd7; i_n_samples = 14'd99;
    n_checks++; if (o_busy !== 1'b1) $display("FAIL start_busy: got %b want 1", o_busy); else n_pass++;
    n_checks++; if (res_if.o_res_rdy !== 1'b1) $display("FAIL start_rdy: got %b want 1", res_if.o_res_rdy); else n_pass++;
  endtask

  // Drives i_res_vld until PS_READ is observed, logging every accept.
  // poke: pulse i_start during RUN and hold i_ps_ack during DRAIN.
  task automatic collect(input bit rand_vld, input bit poke, input int exp_acc, input int budget);
    n_acc = 0; ps_cyc = -1;
    for (int i = 0; i < 32; i++) begin acc_cyc[i] = 0; acc_slot[i] = 14'h3fff; end
    for (int k = 0; k < budget; k++) begin
      if (o_is_ps_read) begin ps_cyc = cyc; break; end
      res_if.i_res_vld = rand_vld ? 1'($urandom_range(0, 1)) : 1'b1;
      i_ps_ack = poke && (n_acc >= exp_acc);
      i_start  = poke && (n_acc == 1);
      @(negedge clk);
      if (res_if.o_accum_vld) begin
        $display("accept cyc=%0d slot=%0d", cyc, res_if.o_vote_slot);
        if (n_acc < 32) begin acc_cyc[n_acc] = cyc; acc_slot[n_acc] = res_if.o_vote_slot; end
        n_acc++;
      end
      @(posedge clk); #1;
    end
    i_ps_ack = 1'b0; i_start = 1'b0;
    n_checks++; if (ps_cyc < 0) $display("FAIL ps_read_timeout: got never want within %0d cycles", budget); else n_pass++;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if ({o_busy, res_if.o_res_rdy, res_if.o_accum_vld, o_is_ps_read, o_done_irq, o_cfg_err, o_is_clf} !== 7'b0)
      $display("FAIL reset_flags: got %b want 0", {o_busy, res_if.o_res_rdy, res_if.o_accum_vld, o_is_ps_read, o_done_irq, o_cfg_err, o_is_clf}); else n_pass++;
    @(negedge clk); @(negedge clk);
    n_checks++; if ({res_if.o_vote_slot, o_n_labels} !== 18'b0) $display("FAIL reset_slot_labels: got %h want 0", {res_if.o_vote_slot, o_n_labels}); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clf_basic;
    do_start(1'b1, 4'd3, 8'd2, 14'd2);
    collect(1'b0, 1'b0, 4, 200);
    n_checks++; if (n_acc !== 4) $display("FAIL basic_count: got %0d want 4", n_acc); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 5) $display("FAIL basic_spacing%0d: got %0d want 5", i, acc_cyc[i] - acc_cyc[i-1]); else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (acc_slot[i] !== 14'(i / 2)) $display("FAIL basic_slot%0d: got %0d want %0d", i, acc_slot[i], i / 2); else n_pass++;
    end
    // Leaves RUN on the edge after the last accept cycle; PS_READ 11 edges later.
    n_checks++; if (ps_cyc - acc_cyc[3] !== 12) $display("FAIL basic_drain: got %0d want 12", ps_cyc - acc_cyc[3]); else n_pass++;
    n_checks++; if ({o_is_clf, o_n_labels, o_done_irq} !== {1'b1, 4'd3, 1'b1}) $display("FAIL basic_latched: got %b want 1_0011_1", {o_is_clf, o_n_labels, o_done_irq}); else n_pass++;
    res_if.i_res_vld = 1'b0; i_ps_ack = 1'b1;
    @(posedge clk); #1;
    i_ps_ack = 1'b0;
    n_checks++; if ({o_busy, o_is_ps_read, res_if.o_vote_slot} !== 16'b0) $display("FAIL basic_ack: got %h want 0", {o_busy, o_is_ps_read, res_if.o_vote_slot}); else n_pass++;
  endtask

  task automatic test_clf_wide;
    do_start(1'b1, 4'd10, 8'd3, 14'd1);
    collect(1'b0, 1'b0, 3, 200);
    n_checks++; if (n_acc !== 3) $display("FAIL wide_count: got %0d want 3", n_acc); else n_pass++;
    for (int i = 1; i < 3; i++) begin
      n_checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 10) $display("FAIL wide_spacing%0d: got %0d want 10", i, acc_cyc[i] - acc_cyc[i-1]); else n_pass++;
    end
    n_checks++; if (ps_cyc - acc_cyc[2] !== 19) $display("FAIL wide_drain: got %0d want 19", ps_cyc - acc_cyc[2]); else n_pass++;
    res_if.i_res_vld = 1'b0; i_ps_ack = 1'b1;
    @(posedge clk); #1;
    i_ps_ack = 1'b0;
  endtask

  task automatic test_ignored;
    do_start(1'b1, 4'd3, 8'd1, 14'd2);
    // Stray i_start in RUN carries a different, valid configuration.
    i_is_clf = 1'b1; i_n_labels = 4'd10; i_n_trees = 8'd3; i_n_samples = 14'd1;
    collect(1'b0, 1'b1, 2, 200);
    n_checks++; if (n_acc !== 2) $display("FAIL ign_count: got %0d want 2", n_acc); else n_pass++;
    n_checks++; if (acc_cyc[1] - acc_cyc[0] !== 5) $display("FAIL ign_spacing: got %0d want 5", acc_cyc[1] - acc_cyc[0]); else n_pass++;
    n_checks++; if (acc_slot[1] !== 14'd1) $display("FAIL ign_slot: got %0d want 1", acc_slot[1]); else n_pass++;
    n_checks++; if (ps_cyc - acc_cyc[1] !== 12) $display("FAIL ign_drain: got %0d want 12", ps_cyc - acc_cyc[1]); else n_pass++;
    // i_res_vld is still high in PS_READ.
    @(negedge clk);
    n_checks++; if ({res_if.o_accum_vld, res_if.o_res_rdy} !== 2'b00) $display("FAIL ign_psread_vld: got %b want 00", {res_if.o_accum_vld, res_if.o_res_rdy}); else n_pass++;
    n_checks++; if (o_n_labels !== 4'd3) $display("FAIL ign_labels: got %0d want 3", o_n_labels); else n_pass++;
    @(posedge clk); #1;
    i_start = 1'b1; i_ps_ack = 1'b1; res_if.i_res_vld = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0; i_ps_ack = 1'b0;
    n_checks++; if ({o_busy, o_is_ps_read, o_cfg_err} !== 3'b000) $display("FAIL overlap_idle: got %b want 000", {o_busy, o_is_ps_read, o_cfg_err}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL overlap_stay_idle: got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_regression_random;
    do_start(1'b0, 4'd0, 8'd1, 14'd4);
    collect(1'b1, 1'b0, 4, 400);
    n_checks++; if (n_acc !== 4) $display("FAIL reg_count: got %0d want 4", n_acc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (acc_slot[i] !== 14'(i)) $display("FAIL reg_slot%0d: got %0d want %0d", i, acc_slot[i], i); else n_pass++;
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (acc_cyc[i] - acc_cyc[i-1] < 5) $display("FAIL reg_gap%0d: got %0d want >=5", i, acc_cyc[i] - acc_cyc[i-1]); else n_pass++;
    end
    n_checks++; if (ps_cyc - acc_cyc[3] !== 9) $display("FAIL reg_drain: got %0d want 9", ps_cyc - acc_cyc[3]); else n_pass++;
    res_if.i_res_vld = 1'b0; i_ps_ack = 1'b1;
    @(posedge clk); #1;
    i_ps_ack = 1'b0;
  endtask

  task automatic cfg_reject(input string name, input logic clf, input logic [3:0] nl,
                            input logic [7:0] nt, input logic [13:0] ns);
    i_is_clf = clf; i_n_labels = nl; i_n_trees = nt; i_n_samples = ns; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    n_checks++; if (o_cfg_err !== 1'b1) $display("FAIL %s_err: got %b want 1", name, o_cfg_err); else n_pass++;
    // Last accepted batch was regression with n_labels 0; nothing may move.
    n_checks++; if ({o_busy, res_if.o_res_rdy, o_is_ps_read, o_done_irq, o_is_clf, o_n_labels, res_if.o_vote_slot} !== 23'b0)
      $display("FAIL %s_quiet: got %h want 0", name, {o_busy, res_if.o_res_rdy, o_is_ps_read, o_done_irq, o_is_clf, o_n_labels, res_if.o_vote_slot}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({o_cfg_err, o_busy} !== 2'b00) $display("FAIL %s_pulse: got %b want 00", name, {o_cfg_err, o_busy}); else n_pass++;
  endtask

  task automatic test_cfg_errors;
    cfg_reject("cap", 1'b1, 4'd10, 8'd1, 14'd1639);
    cfg_reject("trees0", 1'b1, 4'd3, 8'd0, 14'd1);
    cfg_reject("labels1", 1'b1, 4'd1, 8'd1, 14'd1);
  endtask

  task automatic test_reset_mid_batch;
    // 8 x 2048 is exactly the BRAM capacity.
    do_start(1'b1, 4'd8, 8'd1, 14'd2048);
    n_checks++; if ({o_cfg_err, o_n_labels} !== {1'b0, 4'd8}) $display("FAIL cap_ok: got %b want 0_1000", {o_cfg_err, o_n_labels}); else n_pass++;
    res_if.i_res_vld = 1'b1;
    @(negedge clk);
    n_checks++; if ({res_if.o_accum_vld, res_if.o_vote_slot} !== 15'h4000) $display("FAIL mid_accept: got %h want 4000", {res_if.o_accum_vld, res_if.o_vote_slot}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({res_if.o_res_rdy, res_if.o_vote_slot} !== 15'd1) $display("FAIL mid_slot: got %h want 0001", {res_if.o_res_rdy, res_if.o_vote_slot}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++; if ({o_busy, res_if.o_res_rdy, res_if.o_accum_vld, o_is_ps_read, o_done_irq, o_cfg_err, o_is_clf, o_n_labels, res_if.o_vote_slot} !== 25'b0)
      $display("FAIL mid_reset: got %h want 0", {o_busy, res_if.o_res_rdy, res_if.o_accum_vld, o_is_ps_read, o_done_irq, o_cfg_err, o_is_clf, o_n_labels, res_if.o_vote_slot}); else n_pass++;
    @(negedge clk);
    rst = 1'b0; res_if.i_res_vld = 1'b0;
    @(posedge clk); #1;
    do_start(1'b0, 4'd0, 8'd2, 14'd1);
    collect(1'b0, 1'b0, 2, 200);
    n_checks++; if (n_acc !== 2) $display("FAIL fresh_count: got %0d want 2", n_acc); else n_pass++;
    n_checks++; if (acc_cyc[1] - acc_cyc[0] !== 5) $display("FAIL fresh_spacing: got %0d want 5", acc_cyc[1] - acc_cyc[0]); else n_pass++;
    n_checks++; if ({acc_slot[0], acc_slot[1]} !== 28'b0) $display("FAIL fresh_slots: got %0d,%0d want 0,0", acc_slot[0], acc_slot[1]); else n_pass++;
    n_checks++; if (ps_cyc - acc_cyc[1] !== 9) $display("FAIL fresh_drain: got %0d want 9", ps_cyc - acc_cyc[1]); else n_pass++;
    res_if.i_res_vld = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if ({o_is_ps_read, o_done_irq, o_busy} !== 3'b000) $display("FAIL psread_async_drop: got %b want 000", {o_is_ps_read, o_done_irq, o_busy}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    res_if.i_res_vld = 1'b0;
    test_reset();
    test_clf_basic();
    test_clf_wide();
    test_ignored();
    test_regression_random();
    test_cfg_errors();
    test_reset_mid_batch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
